// File: rtl/uart_rx_channel.sv
// ---------------------------------------------------------------------------
// uart_rx_channel : 8N1 serial receiver feeding a FWFT byte FIFO, rts flow ctrl
// Optional 8E1 framing when UART_RX_PARITY_EN is defined.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_channel #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int RTS_HEADROOM = 2
) (
  input  logic                          physical_clock,
  input  logic                          n_reset,
  input  logic                          rx,
  output logic                          rts,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] HALF_TICK  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_TICK  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HEADROOM_C = CW'(RTS_HEADROOM);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            rx_meta, rx_sync, rx_prev;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_next;
  logic            full, pop, push, sample_stop, parity_ok;

  always_ff @(posedge physical_clock) begin
    if (!n_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign full        = (fifo_count == DEPTH_C);
  assign rd_valid    = (fifo_count != '0);
  assign rd_data     = rd_valid ? mem[rd_ptr] : 8'h00;
  assign pop         = rd_en && rd_valid;
  assign sample_stop = (state == STOP) && (baud_cnt == FULL_TICK);
  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  assign push        = sample_stop && parity_ok && rx_sync && (!full || pop);

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  assign parity_ok = ((^shift) == parity_bit);
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge physical_clock) begin
    if (!n_reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == HALF_TICK) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == FULL_TICK) begin
            baud_cnt <= '0;
            shift    <= {rx_sync, shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == FULL_TICK) begin
            baud_cnt   <= '0;
            parity_bit <= rx_sync;
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == FULL_TICK) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (!parity_ok) begin
`ifdef UART_RX_PARITY_EN
              parity_err <= 1'b1;
`endif
            end else if (!rx_sync) begin
              frame_err <= 1'b1;
            end else if (full && !pop) begin
              overrun <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_next = fifo_count;
    if (push && !pop)
      count_next = fifo_count + 1'b1;
    else if (!push && pop)
      count_next = fifo_count - 1'b1;
  end

  always_ff @(posedge physical_clock) begin
    if (push)
      mem[wr_ptr] <= shift;
  end

  always_ff @(posedge physical_clock) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rts        <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      rts        <= ((DEPTH_C - count_next) > HEADROOM_C);
    end
  end

endmodule

`default_nettype wire
